// File: rtl/pipe_csel_adder_if.sv
// Operand/result stream bundle for pipe_csel_adder.
// slave: the adder itself; master: the producer/consumer side driving it.
interface pipe_csel_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder/subtractor, one SEG-bit segment per stage.
// Each stage carries the full operand/sum words; stage k only consumes
// segment k of the operands and only writes segment k of the sum, which
// gives the operand skew and result deskew without separate delay lines.
// Optional feature: define CSEL_SAT_EN to clamp the result on signed overflow.
module pipe_csel_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic             clk,
  input logic             rst_n,
  pipe_csel_adder_if.slave bus
);
  // WIDTH must be a multiple of SEG and at least SEG.
  localparam int unsigned NSEG = WIDTH / SEG;
  localparam int unsigned LAST = NSEG - 1;

  // Stage registers
  logic             v_q [NSEG];
  logic             c_q [NSEG];
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             ovf_q;

  // Stage inputs and next values
  logic             v_i   [NSEG];
  logic             c_i   [NSEG];
  logic [WIDTH-1:0] a_i   [NSEG];
  logic [WIDTH-1:0] b_i   [NSEG];
  logic [WIDTH-1:0] s_i   [NSEG];
  logic [SEG:0]     cand0 [NSEG];
  logic [SEG:0]     cand1 [NSEG];
  logic [SEG:0]     sel   [NSEG];
  logic [WIDTH-1:0] s_n   [NSEG];
  logic             c_n   [NSEG];
  logic [WIDTH-1:0] fin_sum;
  logic             msb_cin;
  logic             ovf_n;
  logic             stall;

  assign stall         = v_q[LAST] && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = v_q[LAST];
  assign bus.out_sum   = s_q[LAST];
  assign bus.out_cout  = c_q[LAST];
  assign bus.out_ovf   = ovf_q;

  // Stage 0 takes the accepted beat; later stages take the previous stage's registers.
  always_comb begin
    v_i[0] = bus.in_valid && bus.in_ready;
    a_i[0] = bus.in_a;
    b_i[0] = bus.in_b ^ {WIDTH{bus.in_sub}};
    c_i[0] = bus.in_sub | bus.in_cin;
    s_i[0] = '0;
    for (int unsigned k = 1; k < NSEG; k++) begin
      v_i[k] = v_q[k-1];
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      s_i[k] = s_q[k-1];
    end
  end

  // Per-stage carry-select: both candidate sums, picked by the incoming carry.
  always_comb begin
    for (int unsigned k = 0; k < NSEG; k++) begin
      cand0[k] = {1'b0, a_i[k][k*SEG +: SEG]} + {1'b0, b_i[k][k*SEG +: SEG]};
      cand1[k] = cand0[k] + {{SEG{1'b0}}, 1'b1};
      sel[k]   = c_i[k] ? cand1[k] : cand0[k];
      s_n[k]   = s_i[k];
      s_n[k][k*SEG +: SEG] = sel[k][SEG-1:0];
      c_n[k]   = sel[k][SEG];
    end
  end

  // Final stage: signed overflow from MSB carry-in vs carry-out, optional clamp.
  always_comb begin
    msb_cin = a_i[LAST][WIDTH-1] ^ b_i[LAST][WIDTH-1] ^ s_n[LAST][WIDTH-1];
    ovf_n   = msb_cin ^ c_n[LAST];
    fin_sum = s_n[LAST];
`ifdef CSEL_SAT_EN
    if (ovf_n) begin
      fin_sum = a_i[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Whole pipeline advances together unless the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < NSEG; k++) begin
        v_q[k] <= v_i[k];
        c_q[k] <= c_n[k];
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= (k == LAST) ? fin_sum : s_n[k];
      end
      ovf_q <= ovf_n;
    end
  end
endmodule

// File: tb/tb_pipe_csel_adder.sv
// Scoreboard bench for pipe_csel_adder (WIDTH=32, SEG=8).
module tb_pipe_csel_adder;
  localparam int WIDTH = 32;
  localparam int SEG   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_csel_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_csel_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [33:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, sum} from plain wide arithmetic and the sign rule.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
    logic [31:0] beff;
    logic [32:0] full;
    logic [31:0] sum;
    logic        ovf;
    beff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {32'd0, (sub ? 1'b1 : cin)};
    sum  = full[31:0];
    ovf  = (a[31] == beff[31]) && (sum[31] != a[31]);
`ifdef CSEL_SAT_EN
    if (ovf) sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {full[32], ovf, sum};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    q.push_back(model(a, b, cin, sub));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    chk("accept", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  // Monitor: handshake rule, stall stability, scoreboard pop on transfer.
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out;
  always @(negedge clk) begin
    logic [33:0] exp;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall)
        chk("stall_hold", {bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_sum}, prev_out);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious", bus.out_valid, 1'b0);
        end else begin
          exp = q.pop_front();
          chk("result", {bus.out_cout, bus.out_ovf, bus.out_sum}, exp);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_valid, bus.out_cout, bus.out_ovf, bus.out_sum};
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_sum",   bus.out_sum,   32'd0);
    chk("rst_cout",  bus.out_cout,  1'b0);
    chk("rst_ovf",   bus.out_ovf,   1'b0);
    chk("rst_ready", bus.in_ready,  1'b1);
    rst_n = 1'b1;

    // First beat, accepted at the first edge after release; latency 4.
    send(32'h0000_00FF, 32'h1, 1'b0, 1'b0);
    idle();
    chk("lat_e0", bus.out_valid, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("lat_early", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("lat_4", bus.out_valid, 1'b1);
    chk("lat_sum", bus.out_sum, 32'h0000_0100);
    drain();

    // Ripple, subtract with cin ignored, overflow / saturation cases.
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    send(32'd5, 32'd7, 1'b1, 1'b1);
    send(32'd5, 32'd7, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    idle();
    drain();

    // Backpressure: 8 beats, out_ready low for 3 cycles from the first result.
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i, i, 1'b0, 1'b0);
        idle();
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!bus.out_valid && n < 50);
        chk("bp_first", bus.out_sum, 32'd2);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight, the oldest already at the output.
    send(32'd10, 32'd1, 1'b0, 1'b0);
    send(32'd20, 32'd2, 1'b0, 1'b0);
    send(32'd30, 32'd3, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #1;
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_sum",   bus.out_sum,   32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", bus.out_valid, 1'b0);
    end
    send(32'd2, 32'd3, 1'b0, 1'b0);
    idle();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post_rst_early", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("post_rst_valid", bus.out_valid, 1'b1);
    chk("post_rst_sum",   bus.out_sum,   32'd5);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
